// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, types and register constants for the RV32 register file
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;
    localparam int REG_A1   = 11;
endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read, write and issue ports of the multi-port register file
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic [NWR-1:0]           wr_clr;
    logic                     iss_valid;
    logic [AW-1:0]            iss_rd;
    logic [NREGS-1:0]         busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_valid, iss_rd,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_valid, iss_rd,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with set-over-clear and same-cycle clear lookup
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_rd,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR-1:0]         wr_clr,
    input  logic [NWR-1:0][AW-1:0] wr_addr,
    input  logic [NRD-1:0][AW-1:0] rd_addr,
    output logic [NRD-1:0]         rd_busy,
    output logic [NREGS-1:0]       busy_vec
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] busy_next;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && (int'(iss_rd) != REG_ZERO))
            set_vec[iss_rd] = 1'b1;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && wr_clr[p])
                clr_vec[wr_addr[p]] = 1'b1;
        // A new producer supersedes the one retiring in the same cycle.
        busy_next = (busy_q & ~clr_vec) | set_vec;
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_next;
    end

    // Retirement is visible to decode immediately; a new issue only from next cycle.
    always_comb begin
        rd_busy = '0;
        for (int r = 0; r < NRD; r++)
            rd_busy[r] = busy_q[rd_addr[r]] & ~clr_vec[rd_addr[r]];
    end

    assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with write-through bypass and busy scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter logic [XLEN-1:0] INIT_A0 = 32'h6,
    parameter logic [XLEN-1:0] INIT_A1 = 32'h5
) (
    input logic          clk,
    input logic          rst,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]             mem [NREGS];
    logic [NWR-1:0][NREGS-1:0]   wr_hit;
    logic [NREGS-1:0]            reg_we;
    logic [XLEN-1:0]             reg_wd [NREGS];

    // One-hot target of each port; address zero never hits.
    for (genvar p = 0; p < NWR; p++) begin : g_wr
        assign wr_hit[p] = (bus.wr_en[p] && (int'(bus.wr_addr[p]) != REG_ZERO))
                         ? (NREGS'(1) << bus.wr_addr[p]) : '0;
    end

    always_comb begin
        reg_we = '0;
        for (int i = 0; i < NREGS; i++) begin
            reg_wd[i] = '0;
            for (int p = 0; p < NWR; p++)
                if (wr_hit[p][i]) begin
                    reg_we[i] = 1'b1;
                    reg_wd[i] = bus.wr_data[p];
                end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= (i == REG_A0) ? INIT_A0 : (i == REG_A1) ? INIT_A1 : '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (reg_we[i])
                    mem[i] <= reg_wd[i];
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [XLEN-1:0] data;
        always_comb begin
            data = mem[bus.rd_addr[r]];
            for (int p = 0; p < NWR; p++)
                if (wr_hit[p][bus.rd_addr[r]])
                    data = bus.wr_data[p];
            if (int'(bus.rd_addr[r]) == REG_ZERO)
                data = '0;
        end
        assign bus.rd_data[r] = data;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .wr_en     (bus.wr_en),
        .wr_clr    (bus.wr_clr),
        .wr_addr   (bus.wr_addr),
        .rd_addr   (bus.rd_addr),
        .rd_busy   (bus.rd_busy),
        .busy_vec  (bus.busy_vec)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

    regfile_mp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_clr    = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic clr);
        bus.wr_en[p]   = 1'b1;
        bus.wr_addr[p] = a;
        bus.wr_data[p] = d;
        bus.wr_clr[p]  = clr;
    endtask

    task automatic iss(input logic [4:0] a);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = a;
    endtask

    // Inputs change on negedge, outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        bus.rd_addr = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        bus.rd_addr[0] = 5'd10;
        bus.rd_addr[1] = 5'd11;
        #1;
        chk("rst_a0", bus.rd_data[0], 32'h6);
        chk("rst_a1", bus.rd_data[1], 32'h5);
        chk("rst_busy_vec", bus.busy_vec, 32'h0);
        chk("rst_rd_busy", {30'd0, bus.rd_busy}, 32'h0);
        bus.rd_addr[0] = 5'd3;
        #1;
        chk("rst_r3", bus.rd_data[0], 32'h0);

        step();
        wr(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
        bus.rd_addr[0] = 5'd5;
        #1;
        chk("bypass_same", bus.rd_data[0], 32'hDEAD_BEEF);
        step();
        #1;
        chk("bypass_next", bus.rd_data[0], 32'hDEAD_BEEF);

        step();
        wr(0, 5'd7, 32'h1, 1'b0);
        wr(1, 5'd7, 32'h2, 1'b0);
        bus.rd_addr[0] = 5'd7;
        bus.rd_addr[1] = 5'd7;
        #1;
        chk("conflict_byp0", bus.rd_data[0], 32'h2);
        chk("conflict_byp1", bus.rd_data[1], 32'h2);
        step();
        #1;
        chk("conflict_store", bus.rd_data[0], 32'h2);

        step();
        wr(1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        iss(5'd0);
        bus.rd_addr[0] = 5'd0;
        #1;
        chk("x0_same", bus.rd_data[0], 32'h0);
        step();
        #1;
        chk("x0_next", bus.rd_data[0], 32'h0);
        chk("x0_busy", {31'd0, bus.busy_vec[0]}, 32'h0);

        step();
        iss(5'd8);
        bus.rd_addr[0] = 5'd8;
        #1;
        chk("iss_same_cycle", {31'd0, bus.rd_busy[0]}, 32'h0);
        step();
        #1;
        chk("iss_rd_busy", {31'd0, bus.rd_busy[0]}, 32'h1);
        chk("iss_busy_vec", bus.busy_vec, 32'h0000_0100);
        step();
        wr(0, 5'd8, 32'h88, 1'b1);
        #1;
        chk("clr_rd_busy", {31'd0, bus.rd_busy[0]}, 32'h0);
        chk("clr_byp", bus.rd_data[0], 32'h88);
        chk("clr_vec_same", {31'd0, bus.busy_vec[8]}, 32'h1);
        step();
        #1;
        chk("clr_vec_next", {31'd0, bus.busy_vec[8]}, 32'h0);

        step();
        iss(5'd8);
        step();
        wr(1, 5'd8, 32'h99, 1'b0);
        #1;
        chk("noclr_rd_busy", {31'd0, bus.rd_busy[0]}, 32'h1);
        chk("noclr_byp", bus.rd_data[0], 32'h99);
        step();
        #1;
        chk("noclr_vec", {31'd0, bus.busy_vec[8]}, 32'h1);
        iss(5'd8);
        wr(1, 5'd8, 32'hAA, 1'b1);
        step();
        #1;
        chk("set_over_clr", {31'd0, bus.busy_vec[8]}, 32'h1);
        chk("set_over_data", bus.rd_data[0], 32'hAA);

        iss(5'd3);
        step();
        iss(5'd9);
        step();
        #1;
        chk("pre_rst_vec", bus.busy_vec, 32'h0000_0308);
        rst = 1'b1;
        wr(0, 5'd4, 32'h44, 1'b0);
        iss(5'd12);
        step();
        rst = 1'b0;
        bus.rd_addr[0] = 5'd4;
        bus.rd_addr[1] = 5'd10;
        #1;
        chk("mid_rst_vec", bus.busy_vec, 32'h0);
        chk("mid_rst_r4", bus.rd_data[0], 32'h0);
        chk("mid_rst_a0", bus.rd_data[1], 32'h6);
        bus.rd_addr[0] = 5'd5;
        bus.rd_addr[1] = 5'd8;
        #1;
        chk("mid_rst_r5", bus.rd_data[0], 32'h0);
        chk("mid_rst_rd_busy", {30'd0, bus.rd_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with write-through bypass and a per-register busy scoreboard, for the pipelined RV32 core. It replaces the single-write, two-read file of the single-cycle datapath. It serves NRD decode-stage read ports and NWR writeback ports, for example ALU and load. It tracks which architectural registers have an in-flight producer, so decode can stall on RAW hazards.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, number of architectural registers (power of two); AW = $clog2(NREGS)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- INIT_A0, 32'h6, reset value of register 10
- INIT_A1, 32'h5, reset value of register 11

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×XLEN  read data (combinational)
- rd_busy  out  NRD  addressed register has a pending producer
- wr_en  in  NWR  write strobe per port
- wr_addr  in  NWR×AW  write address per port
- wr_data  in  NWR×XLEN  write data per port
- wr_clr  in  NWR  this write retires the pending producer (clears busy)
- iss_valid  in  1  an instruction with a destination is issuing this cycle
- iss_rd  in  AW  destination of the issuing instruction
- busy_vec  out  NREGS  full scoreboard, for debug and stall logic

## Operation
- Reset, on a posedge with rst=1:
  - All registers become 0, except register 10 = INIT_A0 and register 11 = INIT_A1.
  - busy_vec becomes all 0.
  - Reset overrides any concurrent write or issue in that cycle.
- Register 0:
  - It always reads as 0 and is never busy.
  - Writes and issues targeting address 0 are ignored.
- Writes:
  - On a posedge with wr_en[p]=1 and wr_addr[p]≠0, the register is loaded with wr_data[p].
  - Several ports writing the same address in one cycle: the highest-indexed port wins, for both data and bypass.
- Read, combinational:
  - If any wr_en[p] targets rd_addr[r] (≠0) this cycle, rd_data[r] is the bypassed wr_data of the winning port.
  - Otherwise rd_data[r] is the stored value.
  - Read ports are fully independent and may alias.
- Scoreboard, per register i:
  - Set: iss_valid=1 and iss_rd=i≠0.
  - Clear: any port has wr_en=1, wr_clr=1 and wr_addr=i.
  - Set and clear in the same cycle: set wins, because the new producer supersedes the retiring one.
  - A write with wr_clr=0 updates data but leaves busy unchanged.
  - Only one outstanding producer per register is tracked. Issue to an already-busy register keeps it busy; no counter.
- rd_busy[r]:
  - Equals busy_vec[rd_addr[r]] with the same-cycle clear applied, so a register being retired this cycle reads not-busy, with bypassed data.
  - The same-cycle issue does not affect it; it takes effect next cycle.
- Out-of-range addresses are not possible, since NREGS is a power of two.

## Timing
- All state updates on posedge clk. There is no negedge logic.
- Write-to-read latency is 0 cycles via the bypass. The stored value is visible from the next cycle.
- Issue-to-busy latency is 1 cycle. Clear-to-not-busy is 0 cycles on rd_busy and 1 cycle on busy_vec.
- Reset mid-operation drops all pending busy bits and data in one cycle. In-flight writes in the reset cycle are lost.
- Outputs after reset, with all inputs idle:
  - rd_data = stored value at rd_addr.
  - rd_busy = 0.
  - busy_vec = 0.

## Structure
- Shared package regfile_pkg:
  - XLEN_DEF, NREGS_DEF, AW_DEF.
  - typedef reg_addr_t (logic [AW_DEF-1:0]) and xlen_t.
  - Constants REG_ZERO=0, REG_A0=10, REG_A1=11.
- Sub-module regfile_scoreboard:
  - Owns busy_vec, the set/clear priority and the rd_busy lookup.
- Top level:
  - Holds the storage array, the write-port priority encoder and the per-read-port bypass mux, built with generate loops over NRD and NWR.

## Test plan
1. Reset then read: reset, then rd_addr = {10, 11} gives rd_data = {6, 5}. Address 3 reads 0. busy_vec = 0.
2. Bypass: wr_en[0]=1, wr_addr=5, wr_data=32'hDEAD_BEEF, rd_addr[0]=5 in the same cycle. rd_data[0] = DEADBEEF in that cycle and the next.
3. Port conflict: ports 0 and 1 both write register 7, with values 1 and 2. The same-cycle read returns 2, and register 7 = 2 afterwards.
4. x0 immunity: write 32'hFFFF_FFFF to 0 and issue to 0. rd_data for address 0 stays 0 and busy_vec[0] stays 0.
5. Scoreboard:
   - Issue to rd=8. The next cycle rd_busy=1 for address 8.
   - A write to 8 with wr_clr=1 gives rd_busy=0 in the same cycle. busy_vec[8]=0 next cycle.
   - A simultaneous issue to 8 and clear of 8 leaves busy_vec[8]=1.
6. Reset mid-operation:
   - Busy registers {3, 9}, and a write to 4 in the reset cycle.
   - After reset, busy_vec=0, register 4=0, register 10=6.
